// File: rtl/booth_r4_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
// Holds the FSM state, step sizing and the Booth digit decode.
package booth_r4_pkg;

    localparam int WIDTH    = 32;
    localparam int PW       = 2 * WIDTH;
    localparam int NDIGITS  = WIDTH / 2;
    localparam int MSB_STEP = NDIGITS;
    localparam int STEP_W   = $clog2(NDIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        PP_ZERO,
        PP_P1,
        PP_P2,
        PP_N1,
        PP_N2
    } pp_sel_e;

    localparam logic [2:0] DIG_Z0  = 3'b000;
    localparam logic [2:0] DIG_P1A = 3'b001;
    localparam logic [2:0] DIG_P1B = 3'b010;
    localparam logic [2:0] DIG_P2  = 3'b011;
    localparam logic [2:0] DIG_N2  = 3'b100;
    localparam logic [2:0] DIG_N1A = 3'b101;
    localparam logic [2:0] DIG_N1B = 3'b110;
    localparam logic [2:0] DIG_Z1  = 3'b111;

    function automatic pp_sel_e booth_sel(input logic [2:0] d);
        pp_sel_e sel;
        sel = PP_ZERO;
        unique case (d)
            DIG_Z0, DIG_Z1:   sel = PP_ZERO;
            DIG_P1A, DIG_P1B: sel = PP_P1;
            DIG_P2:           sel = PP_P2;
            DIG_N2:           sel = PP_N2;
            DIG_N1A, DIG_N1B: sel = PP_N1;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_r4_digit_pp.sv
// Booth partial-product magnitude for one radix-4 digit.
// Negative digits return the magnitude plus neg; the caller inverts and adds 1.
module booth_r4_digit_pp
    import booth_r4_pkg::*;
(
    input  logic [WIDTH-1:0] m,
    input  logic             s,
    input  logic [2:0]       digit,
    output logic [PW-1:0]    pp,
    output logic             neg
);

    pp_sel_e       sel;
    logic [PW-1:0] m_ext;

    always_comb begin
        sel   = booth_sel(digit);
        m_ext = {{WIDTH{s & m[WIDTH-1]}}, m};
        pp    = '0;
        neg   = 1'b0;
        unique case (sel)
            PP_ZERO: pp = '0;
            PP_P1:   pp = m_ext;
            PP_P2:   pp = m_ext << 1;
            PP_N1: begin
                pp  = m_ext;
                neg = 1'b1;
            end
            PP_N2: begin
                pp  = m_ext << 1;
                neg = 1'b1;
            end
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative 32x32 radix-4 Booth multiplier: one digit per cycle,
// then an unsigned MSB correction step, with ready/valid on both sides.
module booth_r4_seq_mul
    import booth_r4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mulcand,
    input  logic [WIDTH-1:0] mulplier,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    product
);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [WIDTH-1:0]    m_q, m_d;
    logic [WIDTH-1:0]    y_q, y_d;
    logic                s_q, s_d;
    logic [PW-1:0]       acc_q, acc_d;
    logic [PW-1:0]       product_q, product_d;
    logic                out_valid_q, out_valid_d;

    logic [STEP_W:0]     sh;
    logic [2:0]          digit;
    logic [PW-1:0]       pp;
    logic                neg;
    logic                last_step;
    logic [PW-1:0]       addend;
    logic                cin;
    logic [PW-1:0]       sum;

    booth_r4_digit_pp u_pp (
        .m     (m_q),
        .s     (s_q),
        .digit (digit),
        .pp    (pp),
        .neg   (neg)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;

    // Negative PPs: shift the magnitude, invert, and feed 1 as carry-in.
    always_comb begin
        sh        = {step_q, 1'b0};
        digit     = 3'({y_q, 1'b0} >> sh);
        last_step = (step_q == STEP_W'(MSB_STEP));
        if (last_step) begin
            addend = (!s_q && y_q[WIDTH-1]) ? {m_q, {WIDTH{1'b0}}} : '0;
            cin    = 1'b0;
        end else begin
            addend = (pp << sh) ^ {PW{neg}};
            cin    = neg;
        end
        sum = acc_q + addend + PW'(cin);
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        m_d         = m_q;
        y_d         = y_q;
        s_d         = s_q;
        acc_d       = acc_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = mulcand;
                    y_d     = mulplier;
                    s_d     = sign;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sum;
                if (last_step) begin
                    product_d   = sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            m_q         <= '0;
            y_q         <= '0;
            s_q         <= 1'b0;
            acc_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            m_q         <= m_d;
            y_q         <= y_d;
            s_q         <= s_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Directed and random checks of booth_r4_seq_mul against an
// arithmetic reference product.
module tb_booth_r4_seq_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mulcand;
    logic [31:0] mulplier;
    logic        sign;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;

    int tests = 0;
    int fails = 0;

    booth_r4_seq_mul dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mulcand   (mulcand),
        .mulplier  (mulplier),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic s);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_ready", 64'(in_ready), 64'd1);
        mulcand  = a;
        mulplier = b;
        sign     = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mulcand  = $urandom;
        mulplier = $urandom;
        sign     = 1'($urandom);
    endtask

    task automatic wait_done(input bit rnd, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            out_ready = rnd ? 1'($urandom) : 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid)
            chk("done_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic release_op(input bit rnd);
        int n;
        n = 0;
        do begin
            out_ready = rnd ? 1'($urandom) : 1'b1;
            @(posedge clk);
            #1;
            n++;
        end while (out_valid && n < 50);
        chk("release", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    task automatic full_op(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic s,
                           input bit rnd);
        int lat;
        start_op(a, b, s);
        wait_done(rnd, lat);
        chk({tag, "_lat"}, 64'(lat), 64'd17);
        chk(tag, product, ref_mul(a, b, s));
        release_op(rnd);
    endtask

    initial begin
        logic [63:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        int lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        mulcand   = '0;
        mulplier  = '0;
        sign      = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed corner products.
        start_op(32'hffffffff, 32'hffffffff, 1'b0);
        chk("busy_in_ready", 64'(in_ready), 64'd0);
        wait_done(1'b0, lat);
        chk("u_ff_lat", 64'(lat), 64'd17);
        chk("u_ff", product, 64'hfffffffe00000001);
        release_op(1'b0);
        full_op("s_ff", 32'hffffffff, 32'hffffffff, 1'b1, 1'b0);
        chk("s_ff_const", product, 64'h0000000000000001);
        full_op("s_min2", 32'h80000000, 32'h00000002, 1'b1, 1'b0);
        chk("s_min2_const", product, 64'hffffffff00000000);
        full_op("u_min2", 32'h80000000, 32'h00000002, 1'b0, 1'b0);
        chk("u_min2_const", product, 64'h0000000100000000);
        full_op("u_dead", 32'hdeadbeef, 32'h80000000, 1'b0, 1'b0);
        chk("u_dead_const", product, 64'h6f56df7780000000);

        // Backpressure in DONE, with in_valid pulses that must be ignored.
        start_op(32'h12345678, 32'h9abcdef0, 1'b1);
        wait_done(1'b0, lat);
        held = ref_mul(32'h12345678, 32'h9abcdef0, 1'b1);
        chk("bp_product", product, held);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom);
            mulcand  = $urandom;
            mulplier = $urandom;
            @(posedge clk);
            #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_hold", product, held);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release", 64'(out_valid), 64'd0);
        chk("bp_idle", 64'(in_ready), 64'd1);
        chk("bp_keep", product, held);
        @(posedge clk);
        #1;
        chk("bp_no_restart", 64'(in_ready), 64'd1);

        // Reset in the middle of an operation.
        start_op(32'hcafef00d, 32'h87654321, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_product", product, 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        full_op("after_rst", 32'hdeadbeef, 32'h00000001, 1'b0, 1'b0);
        chk("after_rst_const", product, 64'h00000000deadbeef);

        // Random operands per sign mode with random consumer readiness.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 100; i++) begin
                ra = $urandom;
                rb = $urandom;
                if (i % 10 == 0) ra = {ra[31], 31'h0};
                if (i % 10 == 1) rb = {1'b1, rb[30:0]};
                full_op(s == 0 ? "rand_u" : "rand_s", ra, rb, 1'(s), 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
